opb_event_counter_bank: RTL

OPB_EVENT_COUNTER_BANK -- requirements
Module: opb_event_counter_bank

---
 rtl/opb_counter_pkg.sv | 47 ++++
 rtl/opb_event_counter_ch.sv | 44 ++++
 rtl/opb_event_counter_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/opb_counter_pkg.sv
// Shared register map, control bit positions and parameter limits for the OPB event counter bank.
package opb_counter_pkg;

    localparam int unsigned OFF_CTRL  = 32'h00;
    localparam int unsigned OFF_OVF   = 32'h04;
    localparam int unsigned OFF_SNAP0 = 32'h08;

    localparam int unsigned CTRL_SNAP_BIT = 31;
    localparam int unsigned CTRL_CLR_BIT  = 30;

    localparam int unsigned N_CH_MIN      = 1;
    localparam int unsigned N_CH_MAX      = 16;
    localparam int unsigned CTR_WIDTH_MIN = 1;
    localparam int unsigned CTR_WIDTH_MAX = 32;
    localparam int unsigned OPB_WIDTH     = 32;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_CTRL,
        REG_OVF,
        REG_SNAP
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] ch;
    } reg_decode_t;

    // Decode a byte offset inside the window; sub-word offset bits are ignored.
    function automatic reg_decode_t decode_offset(input logic [31:0] off, input int unsigned n_ch);
        reg_decode_t d;
        logic [31:0] word;
        word  = off >> 2;
        d.sel = REG_NONE;
        d.ch  = '0;
        if (word == OFF_CTRL / 4) begin
            d.sel = REG_CTRL;
        end else if (word == OFF_OVF / 4) begin
            d.sel = REG_OVF;
        end else if (word >= OFF_SNAP0 / 4 && word < OFF_SNAP0 / 4 + n_ch) begin
            d.sel = REG_SNAP;
            d.ch  = 4'(word - OFF_SNAP0 / 4);
        end
        return d;
    endfunction

endpackage

// File: rtl/opb_event_counter_ch.sv
// One event channel: live counter, sticky overflow flag and snapshot register.
module opb_event_counter_ch
    import opb_counter_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = 32,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 event_in,
    input  logic                 clr,
    input  logic                 snap,
    input  logic                 ovf_clr,
    output logic [CTR_WIDTH-1:0] snap_value,
    output logic                 ovf
);

    logic [CTR_WIDTH-1:0] count;
    logic                 at_max;
    logic                 ovf_set;

    assign at_max  = &count;
    // A clear swallows a coincident event, so it cannot overflow either.
    assign ovf_set = event_in && at_max && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            snap_value <= '0;
            ovf        <= 1'b0;
        end else begin
            if (clr) begin
                count <= '0;
            end else if (event_in && !(SATURATE != 0 && at_max)) begin
                count <= count + 1'b1;
            end
            if (snap) begin
                snap_value <= count;
            end
            ovf <= ovf_set || (ovf && !ovf_clr);
        end
    end

endmodule

// File: rtl/opb_event_counter_bank.sv
// OPB slave exposing N_CH event counters with coherent snapshot, clear-all and sticky overflow flags.
module opb_event_counter_bank
    import opb_counter_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01008200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010082FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6",
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CTR_WIDTH    = 32,
    parameter int unsigned SATURATE     = 0
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [N_CH-1:0]         event_in
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX || CTR_WIDTH < CTR_WIDTH_MIN || CTR_WIDTH > CTR_WIDTH_MAX ||
        C_OPB_AWIDTH != OPB_WIDTH || C_OPB_DWIDTH != OPB_WIDTH) begin : g_bad_params
        $error("opb_event_counter_bank: unsupported parameter set");
    end

    // Bus bit 0 is the MSB, so plain assignment keeps numeric values intact.
    logic [31:0] abus;
    logic [31:0] wdata;
    logic [31:0] offset;
    logic        in_window;
    reg_decode_t dec;

    assign abus      = OPB_ABus;
    assign wdata     = OPB_DBus;
    assign offset    = abus - C_BASEADDR;
    assign in_window = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
    assign dec       = decode_offset(offset, N_CH);

    logic        ack_q;
    logic        done_q;
    logic [31:0] dbus_q;
    logic        start;
    logic        wr_en;
    logic        snap_cmd;
    logic        clr_cmd;
    logic [N_CH-1:0] ovf_clr;
    logic [N_CH-1:0] ovf;
    logic [CTR_WIDTH-1:0] snap_value [N_CH];
    logic [31:0] rdata;

    // done_q blocks a second ack while the master keeps select high after the first.
    assign start    = in_window && !ack_q && !done_q;
    assign wr_en    = ack_q && in_window && !OPB_RNW && OPB_BE[3];
    assign snap_cmd = wr_en && (dec.sel == REG_CTRL) && wdata[CTRL_SNAP_BIT];
    assign clr_cmd  = wr_en && (dec.sel == REG_CTRL) && wdata[CTRL_CLR_BIT];

    always_comb begin
        ovf_clr = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ovf_clr[i] = wr_en && (dec.sel == REG_OVF) && wdata[31-i];
        end
    end

    always_comb begin
        rdata = '0;
        case (dec.sel)
            REG_OVF: begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    rdata[31-i] = ovf[i];
                end
            end
            REG_SNAP: begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (dec.ch == 4'(i)) begin
                        rdata[CTR_WIDTH-1:0] = snap_value[i];
                    end
                end
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            dbus_q <= '0;
        end else begin
            ack_q  <= start;
            done_q <= (ack_q || done_q) && OPB_select;
            dbus_q <= (start && OPB_RNW) ? rdata : '0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        opb_event_counter_ch #(
            .CTR_WIDTH (CTR_WIDTH),
            .SATURATE  (SATURATE)
        ) u_ch (
            .clk        (OPB_Clk),
            .rst        (OPB_Rst),
            .event_in   (event_in[i]),
            .clr        (clr_cmd),
            .snap       (snap_cmd),
            .ovf_clr    (ovf_clr[i]),
            .snap_value (snap_value[i]),
            .ovf        (ovf[i])
        );
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[0:2], wdata};

endmodule
